risc_io_port_bank: RTL and testbench

//  Parametrised I/O port bank between the RISC core and the external world; generalises the fixed 4 x 8-bit in/out ports.
//  NUM_PORTS output registers, each with a valid/ack handshake; NUM_PORTS synchronised inputs with sticky change flags.

---
 rtl/rpio_pkg.sv | 18 +
 rtl/rpio_sync.sv | 38 +++
 rtl/risc_io_port_bank.sv | 135 +++++++++++++
 tb/tb_risc_io_port_bank.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpio_pkg.sv
// Shared constants, trace entry layout and port-slice helper for the RISC I/O port bank.
package rpio_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_PORTS = 4;
    localparam int unsigned DEF_PORT_AW   = 2;

    typedef struct packed {
        logic [DEF_PORT_AW-1:0] port;
        logic [DEF_DATA_W-1:0]  data;
    } traceEntry_t;

    // LSB of port p inside a flat NUM_PORTS*width bus
    function automatic int unsigned portLsb(input int unsigned p, input int unsigned width);
        return p * width;
    endfunction

endpackage

// File: rtl/rpio_sync.sv
// One input port: 2-flop synchroniser, sample register and sticky change flag.
module rpio_sync #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] asyncIn,
    input  logic              clearFlag,
    output logic [DATA_W-1:0] syncOut,
    output logic              changeFlag
);

    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;
    logic [DATA_W-1:0] sample;

    // A set on the same edge as a read clear wins so no change is lost
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sample     <= '0;
            changeFlag <= 1'b0;
        end else begin
            sync1  <= asyncIn;
            sync2  <= sync1;
            sample <= sync2;
            if (sync2 != sample) begin
                changeFlag <= 1'b1;
            end else if (clearFlag) begin
                changeFlag <= 1'b0;
            end
        end
    end

    assign syncOut = sync2;

endmodule

// File: rtl/risc_io_port_bank.sv
// Parametrised I/O port bank: handshaked output registers and synchronised inputs.
// Optional write trace FIFO enabled by defining RPIO_TRACE_EN.
module risc_io_port_bank
    import rpio_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
    parameter int unsigned PORT_AW     = DEF_PORT_AW,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [PORT_AW-1:0]          port_addr,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        stall,
    input  logic [NUM_PORTS*DATA_W-1:0] inp_ext,
    output logic [NUM_PORTS*DATA_W-1:0] out_ext,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ack,
`ifdef RPIO_TRACE_EN
    output logic [PORT_AW+DATA_W-1:0]   trace_data,
    output logic                        trace_empty,
    input  logic                        trace_pop,
    output logic                        trace_ovf,
`endif
    output logic [NUM_PORTS-1:0]        inp_changed
);

    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : gBadDepth
        $error("TRACE_DEPTH must be a power of two >= 2");
    end

    logic [NUM_PORTS-1:0] selWr;
    logic [NUM_PORTS-1:0] selRd;
    logic [NUM_PORTS-1:0] accept;
    logic [DATA_W-1:0]    outReg  [NUM_PORTS];
    logic [DATA_W-1:0]    syncVal [NUM_PORTS];

    // Out-of-range addresses match no port, so they write, stall and clear nothing
    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        assign selWr[p]  = wr_en && (port_addr == PORT_AW'(p));
        assign selRd[p]  = rd_en && (port_addr == PORT_AW'(p));
        assign accept[p] = selWr[p] && (!out_valid[p] || out_ack[p]);
        assign out_ext[portLsb(p, DATA_W) +: DATA_W] = outReg[p];

        rpio_sync #(.DATA_W(DATA_W)) uSync (
            .clk        (clk),
            .Reset      (Reset),
            .asyncIn    (inp_ext[portLsb(p, DATA_W) +: DATA_W]),
            .clearFlag  (selRd[p]),
            .syncOut    (syncVal[p]),
            .changeFlag (inp_changed[p])
        );
    end

    assign stall = |(selWr & out_valid & ~out_ack);

    // A write accepted alongside an ack keeps valid high with the new data
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                outReg[p] <= '0;
            end
            out_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (accept[p]) begin
                    outReg[p]    <= wr_data;
                    out_valid[p] <= 1'b1;
                end else if (out_ack[p]) begin
                    out_valid[p] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_addr == PORT_AW'(p)) begin
                rd_data = syncVal[p];
            end
        end
    end

`ifdef RPIO_TRACE_EN
    localparam int unsigned TRACE_W = PORT_AW + DATA_W;
    localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);

    logic [TRACE_W-1:0] traceMem [TRACE_DEPTH];
    logic [PTR_W:0]     wrPtr;
    logic [PTR_W:0]     rdPtr;
    logic               traceFull;
    logic               pushReq;
    logic               doPush;
    logic               doPop;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign trace_empty = (wrPtr == rdPtr);
    assign traceFull   = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                         (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign pushReq     = |accept;
    assign doPop       = trace_pop && !trace_empty;
    assign doPush      = pushReq && (!traceFull || doPop);
    assign trace_data  = traceMem[rdPtr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + (PTR_W+1)'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + (PTR_W+1)'(1);
            end
            if (pushReq && !doPush) begin
                trace_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            traceMem[wrPtr[PTR_W-1:0]] <= {port_addr, wr_data};
        end
    end
`endif

endmodule

// File: tb/tb_risc_io_port_bank.sv
// Directed self-checking bench for risc_io_port_bank (default 4-port build plus a 3-port instance).
module tb_risc_io_port_bank;

    logic        clk = 1'b0;
    logic        Reset;
    logic [1:0]  port_addr;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        stall;
    logic [31:0] inp_ext;
    logic [31:0] out_ext;
    logic [3:0]  out_valid;
    logic [3:0]  out_ack;
    logic [3:0]  inp_changed;

    logic        wrEn3;
    logic [7:0]  rdData3;
    logic        stall3;
    logic [23:0] inpExt3;
    logic [23:0] outExt3;
    logic [2:0]  outValid3;
    logic [2:0]  outAck3;
    logic [2:0]  inpChanged3;

`ifdef RPIO_TRACE_EN
    logic [9:0]  trace_data;
    logic        trace_empty;
    logic        trace_pop;
    logic        trace_ovf;
    logic [9:0]  traceDataU3;
    logic        traceEmptyU3;
    logic        traceOvfU3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    risc_io_port_bank dut (
        .clk         (clk),
        .Reset       (Reset),
        .port_addr   (port_addr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .stall       (stall),
        .inp_ext     (inp_ext),
        .out_ext     (out_ext),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
`ifdef RPIO_TRACE_EN
        .trace_data  (trace_data),
        .trace_empty (trace_empty),
        .trace_pop   (trace_pop),
        .trace_ovf   (trace_ovf),
`endif
        .inp_changed (inp_changed)
    );

    risc_io_port_bank #(.NUM_PORTS(3)) dut3 (
        .clk         (clk),
        .Reset       (Reset),
        .port_addr   (port_addr),
        .wr_en       (wrEn3),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rdData3),
        .stall       (stall3),
        .inp_ext     (inpExt3),
        .out_ext     (outExt3),
        .out_valid   (outValid3),
        .out_ack     (outAck3),
`ifdef RPIO_TRACE_EN
        .trace_data  (traceDataU3),
        .trace_empty (traceEmptyU3),
        .trace_pop   (1'b0),
        .trace_ovf   (traceOvfU3),
`endif
        .inp_changed (inpChanged3)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        port_addr = 2'd2;
        wr_en     = 1'b1;
        wr_data   = 8'h5A;
        rd_en     = 1'b0;
        inp_ext   = '0;
        out_ack   = '0;
        wrEn3     = 1'b0;
        inpExt3   = '0;
        outAck3   = '0;
`ifdef RPIO_TRACE_EN
        trace_pop = 1'b0;
`endif
        #1;
        tick();
        tick();
        checkVal("reset_out_ext", 64'(out_ext), 64'h0);
        checkVal("reset_out_valid", 64'(out_valid), 64'h0);
        checkVal("reset_stall", 64'(stall), 64'h0);
        checkVal("reset_inp_changed", 64'(inp_changed), 64'h0);

        // back-pressure on port 1
        Reset     = 1'b0;
        inpExt3   = 24'hA5A5A5;
        port_addr = 2'd1;
        wr_data   = 8'h11;
        tick();
        checkVal("bp_first_data", 64'(out_ext[15:8]), 64'h11);
        checkVal("bp_first_valid", 64'(out_valid[1]), 64'h1);
        wr_data = 8'h22;
        #1;
        checkVal("bp_stall", 64'(stall), 64'h1);
        tick();
        checkVal("bp_held_data", 64'(out_ext[15:8]), 64'h11);
        out_ack[1] = 1'b1;
        #1;
        checkVal("bp_stall_released", 64'(stall), 64'h0);
        tick();
        checkVal("bp_new_data", 64'(out_ext[15:8]), 64'h22);
        checkVal("bp_new_valid", 64'(out_valid[1]), 64'h1);
        wr_en   = 1'b0;
        out_ack = '0;

        // ack-only on port 0
        port_addr = 2'd0;
        wr_data   = 8'h77;
        wr_en     = 1'b1;
        tick();
        checkVal("ack_pre_valid", 64'(out_valid[0]), 64'h1);
        wr_en      = 1'b0;
        out_ack[0] = 1'b1;
        tick();
        checkVal("ack_valid_cleared", 64'(out_valid[0]), 64'h0);
        checkVal("ack_data_held", 64'(out_ext[7:0]), 64'h77);
        checkVal("ack_other_ports", 64'(out_ext[31:8]), 64'h0022);
        out_ack = '0;

        // input change on port 3
        port_addr       = 2'd3;
        inp_ext[31:24]  = 8'hC3;
        tick();
        checkVal("in_rd_after1", 64'(rd_data), 64'h00);
        tick();
        checkVal("in_rd_after2", 64'(rd_data), 64'hC3);
        checkVal("in_flag_after2", 64'(inp_changed[3]), 64'h0);
        tick();
        checkVal("in_flag_after3", 64'(inp_changed[3]), 64'h1);
        rd_en = 1'b1;
        tick();
        checkVal("in_flag_cleared", 64'(inp_changed[3]), 64'h0);
        rd_en = 1'b0;

        // set and clear on the same edge: set wins
        inp_ext[31:24] = 8'h3C;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        checkVal("in_set_wins", 64'(inp_changed[3]), 64'h1);
        tick();
        checkVal("in_clear_after", 64'(inp_changed[3]), 64'h0);
        rd_en = 1'b0;
        checkVal("in_rd_new", 64'(rd_data), 64'h3C);

        // out-of-range address on the 3-port instance
        checkVal("oor_pre_flags", 64'(inpChanged3), 64'h7);
        wrEn3   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h99;
        #1;
        checkVal("oor_stall", 64'(stall3), 64'h0);
        checkVal("oor_rd_data", 64'(rdData3), 64'h00);
        tick();
        checkVal("oor_out_ext", 64'(outExt3), 64'h0);
        checkVal("oor_out_valid", 64'(outValid3), 64'h0);
        checkVal("oor_flags", 64'(inpChanged3), 64'h7);
        wrEn3 = 1'b0;
        rd_en = 1'b0;

`ifdef RPIO_TRACE_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkVal("tr_empty_reset", 64'(trace_empty), 64'h1);
        port_addr  = 2'd2;
        out_ack[2] = 1'b1;
        wr_en      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'(i + 1);
            tick();
        end
        wr_en   = 1'b0;
        out_ack = '0;
        checkVal("tr_ovf", 64'(trace_ovf), 64'h1);
        for (int i = 0; i < 8; i++) begin
            checkVal("tr_pop_data", 64'(trace_data), 64'({2'd2, 8'(i + 1)}));
            trace_pop = 1'b1;
            tick();
            trace_pop = 1'b0;
        end
        checkVal("tr_empty_end", 64'(trace_empty), 64'h1);
        checkVal("tr_ovf_sticky", 64'(trace_ovf), 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
